// File: rtl/mem_pkg.sv
// Shared constants, funct3 codes, state encoding and the misalignment helper for the MEM stage.
package mem_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_BITS = 5;
  localparam int unsigned ADDR_W   = XLEN - 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Halfword accesses need a[0]=0, word accesses need a[1:0]=0; byte accesses never trap.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_LH, F3_LHU: mis = a[0];
      F3_LW:         mis = (a != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational store lane formatting (byte enables, replicated data) and load extract/extend.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_addr_lo,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_be_c,
  output logic [XLEN-1:0] st_wdata_c,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: misaligned halfwords fall back to the half selected by a[1].
  always_comb begin
    st_be_c    = 4'hF;
    st_wdata_c = st_data;
    case (st_funct3)
      F3_SB: begin
        st_be_c    = 4'(4'b0001 << st_addr_lo);
        st_wdata_c = {4{st_data[7:0]}};
      end
      F3_SH: begin
        st_be_c    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = 8'(ld_rdata >> {ld_addr_lo, 3'b000});
    ld_half   = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data_c = ld_rdata;
    case (ld_funct3)
      F3_LB:   ld_data_c = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data_c = {24'b0, ld_byte};
      F3_LH:   ld_data_c = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data_c = {16'b0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues/handshakes data-memory requests and produces writeback.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [2:0]          ex_funct3,
  input  logic [XLEN-1:0]     ex_alu_result,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic [REG_BITS-1:0] ex_rd,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [3:0]          mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ready,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [REG_BITS-1:0] wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                misalign
);

  state_e              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic                is_load_q, is_load_d;

  logic                stall_d, mem_req_d, mem_we_d, wb_valid_d, wb_we_d, misalign_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [3:0]          mem_be_d;
  logic [XLEN-1:0]     mem_wdata_d, wb_data_d;
  logic [REG_BITS-1:0] wb_rd_d;

  logic [3:0]          st_be_c;
  logic [XLEN-1:0]     st_wdata_c, ld_data_c;
  logic                trap_c;

  mem_lane_fmt u_lane_fmt (
    .st_funct3  (ex_funct3),
    .st_addr_lo (ex_alu_result[1:0]),
    .st_data    (ex_wdata),
    .st_be_c    (st_be_c),
    .st_wdata_c (st_wdata_c),
    .ld_funct3  (f3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_rdata   (mem_rdata),
    .ld_data_c  (ld_data_c)
  );

`ifdef MISALIGN_TRAP_EN
  assign trap_c = is_misaligned(ex_funct3, ex_alu_result[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  // Next-state and next-output logic; request fields hold while waiting in REQ.
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    is_load_d   = is_load_q;
    stall_d     = stall;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we;
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;
    misalign_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_mem_read || ex_mem_write) begin
            if (trap_c) begin
              misalign_d = 1'b1;
            end else begin
              state_d     = ST_REQ;
              stall_d     = 1'b1;
              mem_req_d   = 1'b1;
              mem_we_d    = !ex_mem_read;
              mem_addr_d  = ex_alu_result[XLEN-1:2];
              mem_be_d    = ex_mem_read ? 4'hF : st_be_c;
              mem_wdata_d = st_wdata_c;
              f3_d        = ex_funct3;
              addr_lo_d   = ex_alu_result[1:0];
              rd_d        = ex_rd;
              is_load_d   = ex_mem_read;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = (ex_rd != '0);
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_result;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d    = ST_IDLE;
          stall_d    = 1'b0;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = is_load_q && (rd_q != '0);
          if (is_load_q) wb_data_d = ld_data_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      f3_q      <= '0;
      addr_lo_q <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      stall     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      addr_lo_q <= addr_lo_d;
      rd_q      <= rd_d;
      is_load_q <= is_load_d;
      stall     <= stall_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      wb_valid  <= wb_valid_d;
      wb_we     <= wb_we_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      misalign  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (honours MISALIGN_TRAP_EN).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid      = 1'b1;
    ex_mem_read   = rd_op;
    ex_mem_write  = wr_op;
    ex_funct3     = f3;
    ex_alu_result = a;
    ex_wdata      = wd;
    ex_rd         = rd;
  endtask

  task automatic idle_ex();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
  endtask

  // Full load/store transaction: memory answers in the lat-th REQ cycle.
  task automatic mem_xact(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int lat, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic exp_we,
                          input logic [31:0] exp_data);
    int nstall;
    present(!st, st, f3, a, wd, rd);
    tick();
    idle_ex();
    chk({tag, " req"}, 32'(mem_req), 32'd1);
    chk({tag, " we"}, 32'(mem_we), 32'(st));
    chk({tag, " addr"}, 32'(mem_addr), 32'(a[31:2]));
    chk({tag, " be"}, 32'(mem_be), 32'(exp_be));
    if (st) chk({tag, " wdata"}, mem_wdata, exp_wdata);
    nstall = (stall === 1'b1) ? 1 : 0;
    for (int i = 1; i < lat; i++) begin
      tick();
      if (stall === 1'b1) nstall++;
      chk({tag, " no early wb"}, 32'(wb_valid), 32'd0);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    chk({tag, " stall cycles"}, 32'(nstall), 32'(lat));
    chk({tag, " stall drop"}, 32'(stall), 32'd0);
    chk({tag, " req drop"}, 32'(mem_req), 32'd0);
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, " wb_we"}, 32'(wb_we), 32'(exp_we));
    chk({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
    if (!st) chk({tag, " wb_data"}, wb_data, exp_data);
    tick();
    chk({tag, " wb pulse"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_ex();
    ex_funct3 = '0; ex_alu_result = '0; ex_wdata = '0; ex_rd = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #22;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst be", 32'(mem_be), 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU pass-through
    present(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5);
    tick();
    idle_ex();
    chk("alu wb_valid", 32'(wb_valid), 32'd1);
    chk("alu wb_we", 32'(wb_we), 32'd1);
    chk("alu wb_data", wb_data, 32'h1234);
    chk("alu wb_rd", 32'(wb_rd), 32'd5);
    chk("alu stall", 32'(stall), 32'd0);
    tick();
    chk("alu pulse", 32'(wb_valid), 32'd0);

    // ALU op to x0 must not write
    present(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd0);
    tick();
    idle_ex();
    chk("alu x0 wb_we", 32'(wb_we), 32'd0);
    tick();

    mem_xact("LB", 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80FF_FF7F, 3, 4'hF, 32'h0,
             1'b1, 32'hFFFF_FF80);
    mem_xact("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FF_FF7F, 3, 4'hF, 32'h0,
             1'b1, 32'h0000_0080);
    mem_xact("SH", 1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd9, 32'h0, 1, 4'b1100,
             32'hBEEF_BEEF, 1'b0, 32'h0);
    mem_xact("SB", 1'b1, 3'b000, 32'h101, 32'h1234_56A5, 5'd2, 32'h0, 2, 4'b0010,
             32'hA5A5_A5A5, 1'b0, 32'h0);
    mem_xact("SW", 1'b1, 3'b010, 32'h400, 32'h0BAD_F00D, 5'd2, 32'h0, 1, 4'hF,
             32'h0BAD_F00D, 1'b0, 32'h0);
    mem_xact("LH", 1'b0, 3'b001, 32'h102, 32'h0, 5'd11, 32'h8001_0002, 1, 4'hF, 32'h0,
             1'b1, 32'hFFFF_8001);
    mem_xact("LHU", 1'b0, 3'b101, 32'h100, 32'h0, 5'd11, 32'h8001_F002, 1, 4'hF, 32'h0,
             1'b1, 32'h0000_F002);
    mem_xact("LW x0", 1'b0, 3'b010, 32'h10, 32'h0, 5'd0, 32'h1111_2222, 1, 4'hF, 32'h0,
             1'b0, 32'h1111_2222);
    mem_xact("LD+ST", 1'b0, 3'b010, 32'h14, 32'h0, 5'd6, 32'h3333_4444, 1, 4'hF, 32'h0,
             1'b1, 32'h3333_4444);

    // LW followed back-to-back by an ALU op held during the stall
    present(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd3);
    tick();
    present(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd9);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ready = 1'b0;
    chk("b2b lw wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b lw wb_rd", 32'(wb_rd), 32'd3);
    chk("b2b lw wb_data", wb_data, 32'hCAFE_F00D);
    chk("b2b stall", 32'(stall), 32'd0);
    tick();
    idle_ex();
    chk("b2b alu wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b alu wb_rd", 32'(wb_rd), 32'd9);
    chk("b2b alu wb_data", wb_data, 32'h55);
    tick();
    chk("b2b no dup", 32'(wb_valid), 32'd0);

    // Reset while a request is outstanding
    present(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd4);
    tick();
    idle_ex();
    chk("abort req before", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort req", 32'(mem_req), 32'd0);
    chk("abort stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort no wb", 32'(wb_valid), 32'd0);
      chk("abort no req", 32'(mem_req), 32'd0);
    end

    // Misaligned LW
`ifdef MISALIGN_TRAP_EN
    present(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 5'd4);
    tick();
    idle_ex();
    chk("mis req", 32'(mem_req), 32'd0);
    chk("mis pulse", 32'(misalign), 32'd1);
    chk("mis wb_valid", 32'(wb_valid), 32'd0);
    chk("mis stall", 32'(stall), 32'd0);
    tick();
    chk("mis pulse end", 32'(misalign), 32'd0);
    chk("mis no wb", 32'(wb_valid), 32'd0);
`else
    mem_xact("LW mis", 1'b0, 3'b010, 32'h301, 32'h0, 5'd4, 32'h1234_5678, 1, 4'hF, 32'h0,
             1'b1, 32'h1234_5678);
    chk("mis tied", 32'(misalign), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
